// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, bubble encoding and fetch FSM state codes.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StFull = 2'd2;
    localparam logic [1:0] StKill = 2'd3;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch handshake: req/addr held until a one-cycle ack returns rdata.
interface if_fetch_stage_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic                        req;
    logic [ADDR_W-1:0]           addr;
    logic                        ack;
    logic [cpu_pkg::INSTR_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/if_fetch_stage_buffer.sv
// One-entry fetch buffer holding {valid, instruction, PC+4}; flush beats load beats consume.
module if_fetch_stage_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               consume_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            // A load may coincide with consumption of the old entry.
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (consume_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = valid_q ? instr_q : NOP_INSTR;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC and fetch FSM over a req/ack memory port, feeding a one-entry
// buffer that presents {PC+4, instruction, valid} to the IF/ID register.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               freeze_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_addr_i,
    if_fetch_stage_if.master   imem_io,
    output logic [ADDR_W-1:0]  pc_out_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               fetch_valid_o,
    output logic               fetch_stall_o
);

    localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic              valid;
    logic              consume;
    logic              buf_free;
    logic              load;
    logic [1:0]        unused_br_lsb;

    assign pc_inc        = pc_q + PcStep;
    assign br_target     = {branch_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_br_lsb = branch_addr_i[1:0];
    assign consume       = valid && !freeze_i;
    assign buf_free      = !valid || consume;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        load        = 1'b0;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (branch_taken_i) begin
                    // Outstanding fetch must complete at its original address before redirect.
                    state_d     = imem_io.ack ? StReq : StKill;
                    kill_addr_d = pc_q;
                end else if (imem_io.ack) begin
                    if (buf_free) begin
                        load    = 1'b1;
                        pc_d    = pc_inc;
                        state_d = StReq;
                    end else begin
                        // Buffer frozen: drop the word, PC unchanged so it is refetched later.
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (branch_taken_i || consume) begin
                    state_d = StReq;
                end
            end
            StKill: begin
                if (imem_io.ack) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
        if (branch_taken_i) begin
            pc_d = br_target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            kill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
        end
    end

    assign imem_io.req  = (state_q == StReq) || (state_q == StKill);
    assign imem_io.addr = (state_q == StKill) ? kill_addr_q : pc_q;

    if_fetch_stage_buffer #(
        .ADDR_W(ADDR_W)
    ) u_buffer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (branch_taken_i),
        .load_i   (load),
        .consume_i(consume),
        .instr_i  (imem_io.rdata),
        .pc_i     (pc_inc),
        .valid_o  (valid),
        .instr_o  (instruction_o),
        .pc_o     (pc_out_o)
    );

    assign fetch_valid_o = valid;
    assign fetch_stall_o = ~valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory model, consumption scoreboard,
// a table of streaming scenarios and hand-written redirect/freeze/reset sequences.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        freeze = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] baddr  = '0;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        valid;
    logic        stall;

    if_fetch_stage_if #(.ADDR_W(ADDR_W)) mif ();

    if_fetch_stage #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .freeze_i      (freeze),
        .branch_taken_i(branch),
        .branch_addr_i (baddr),
        .imem_io       (mif),
        .pc_out_o      (pc_out),
        .instruction_o (instr),
        .fetch_valid_o (valid),
        .fetch_stall_o (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_out;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        int unsigned lat;
        logic [31:0] base;
        int unsigned n;
        int unsigned frz_period;
        logic [31:0] exp_last_pc_out;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    bit          sb_en = 1'b0;
    int unsigned mem_lat = 0;
    bit          late_ack_req = 1'b0;
    int unsigned wait_cnt = 0;
    logic [31:0] last_pc_out = '0;
    vec_t        vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'd7 + 32'h1357_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: ack after mem_lat waiting cycles, plus an optional stray ack.
    initial begin
        mif.ack   = 1'b0;
        mif.rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            mif.ack = 1'b0;
            if (late_ack_req) begin
                mif.ack      = 1'b1;
                mif.rdata    = 32'hBAD0_BAD0;
                late_ack_req = 1'b0;
                wait_cnt     = 0;
            end else if (rst_n && mif.req) begin
                if (wait_cnt >= mem_lat) begin
                    mif.ack   = 1'b1;
                    mif.rdata = mem_word(mif.addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Per-cycle invariants and consumption scoreboard.
    initial begin
        logic        prev_req;
        logic        prev_ack;
        logic [31:0] prev_addr;
        logic        nv;
        exp_t        e;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                nv = ~valid;
                chk("stall_is_not_valid", stall, nv);
                if (!valid) chk("instr_zero_when_invalid", instr, 32'h0);
                if (prev_req && !prev_ack && mif.req) chk("addr_stable", mif.addr, prev_addr);
                if (sb_en && valid && !freeze && !branch) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra: got pc_out %h expected none", pc_out);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_pc_out", pc_out, e.pc_out);
                        chk("sb_instr", instr, e.instr);
                        last_pc_out = pc_out;
                    end
                end
            end
            prev_req  = rst_n && mif.req;
            prev_ack  = mif.ack;
            prev_addr = mif.addr;
        end
    end

    task automatic cyc(input logic f, input logic b, input logic [31:0] ba);
        @(negedge clk);
        freeze = f || (sb_en && sb_q.size() == 0);
        branch = b;
        baddr  = ba;
        #2;
    endtask

    task automatic do_reset(input logic [31:0] start);
        @(negedge clk);
        rst_n  = 1'b0;
        freeze = 1'b0;
        branch = 1'b0;
        baddr  = '0;
        #2;
        chk("rst_req", mif.req, 32'h0);
        chk("rst_valid", valid, 32'h0);
        chk("rst_stall", stall, 32'h1);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        branch = (start != RESET_PC);
        baddr  = start;
        #2;
    endtask

    task automatic push_seq(input logic [31:0] base, input int unsigned n);
        logic [31:0] a;
        a = base & 32'hFFFF_FFFC;
        for (int k = 0; k < int'(n); k++) begin
            sb_q.push_back('{pc_out: a + 32'd4, instr: mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic run_until_empty(input int unsigned budget, input int unsigned period);
        int unsigned c;
        c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            cyc((period != 0) && (c % period == period - 1), 1'b0, 32'h0);
            c++;
        end
        chk("sb_drained", sb_q.size(), 32'h0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{0, 32'h0000_0000, 8, 0, 32'h0000_0020};
        vecs[1] = '{3, 32'h0000_0040, 4, 0, 32'h0000_0050};
        vecs[2] = '{0, 32'h0000_1000, 10, 3, 32'h0000_1028};
        vecs[3] = '{1, 32'hFFFF_FFF0, 8, 2, 32'h0000_0010};
        vecs[4] = '{2, 32'h0000_0082, 6, 0, 32'h0000_0098};

        for (int i = 0; i < 5; i++) begin
            v       = vecs[i];
            mem_lat = v.lat;
            do_reset(v.base);
            sb_en = 1'b1;
            push_seq(v.base, v.n);
            run_until_empty(400, v.frz_period);
            chk("vec_last_pc_out", last_pc_out, v.exp_last_pc_out);
            sb_en = 1'b0;
        end

        // Back-to-back streaming with single-cycle memory.
        mem_lat = 0;
        do_reset(RESET_PC);
        chk("t1_idle_req", mif.req, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t1_c2_req", mif.req, 32'h1);
        chk("t1_c2_addr", mif.addr, 32'h0);
        chk("t1_c2_valid", valid, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk("t1_valid", valid, 32'h1);
            chk("t1_pc_out", pc_out, 32'(4 * (k + 1)));
            chk("t1_instr", instr, mem_word(32'(4 * k)));
            chk("t1_addr", mif.addr, 32'(4 * (k + 1)));
        end

        // Three-cycle memory latency: one instruction every four cycles.
        mem_lat = 3;
        do_reset(RESET_PC);
        for (int c = 2; c <= 13; c++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (c <= 5) chk("t2_addr_wait", mif.addr, 32'h0);
            if (c >= 6 && (c - 6) % 4 == 0) begin
                chk("t2_valid", valid, 32'h1);
                chk("t2_pc_out", pc_out, 32'(4 * ((c - 6) / 4 + 1)));
            end else begin
                chk("t2_bubble", valid, 32'h0);
            end
        end

        // Freeze for five cycles with the buffer full.
        mem_lat = 0;
        do_reset(RESET_PC);
        sb_en = 1'b1;
        push_seq(32'h0, 5);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("t3_full_valid", valid, 32'h1);
        chk("t3_full_pc_out", pc_out, 32'h8);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk("t3_frz_req", mif.req, 32'h0);
            chk("t3_frz_pc_out", pc_out, 32'h8);
            chk("t3_frz_instr", instr, mem_word(32'h4));
        end
        cyc(1'b0, 1'b0, 32'h0);
        chk("t3_resume_pc_out", pc_out, 32'h8);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t3_refetch_req", mif.req, 32'h1);
        chk("t3_refetch_addr", mif.addr, 32'h8);
        run_until_empty(50, 0);
        chk("t3_last_pc_out", last_pc_out, 32'h14);
        sb_en = 1'b0;

        // Branch while a fetch is outstanding: old fetch completes, data dropped.
        mem_lat = 2;
        do_reset(RESET_PC);
        cyc(1'b0, 1'b1, 32'h100);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk("t4_kill_req", mif.req, 32'h1);
            chk("t4_kill_addr", mif.addr, 32'h0);
            chk("t4_kill_valid", valid, 32'h0);
        end
        cyc(1'b0, 1'b0, 32'h0);
        chk("t4_new_addr", mif.addr, 32'h100);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk("t4_wait_valid", valid, 32'h0);
        end
        cyc(1'b0, 1'b0, 32'h0);
        chk("t4_valid", valid, 32'h1);
        chk("t4_pc_out", pc_out, 32'h104);
        chk("t4_instr", instr, mem_word(32'h100));

        // Branch coincident with ack and freeze; target low bits ignored.
        mem_lat = 0;
        do_reset(RESET_PC);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h203);
        chk("t5_pre_valid", valid, 32'h1);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t5_flushed", valid, 32'h0);
        chk("t5_addr", mif.addr, 32'h200);
        chk("t5_req", mif.req, 32'h1);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t5_valid", valid, 32'h1);
        chk("t5_pc_out", pc_out, 32'h204);
        chk("t5_instr", instr, mem_word(32'h200));

        // Reset mid-wait followed by a stray ack while idle.
        mem_lat = 3;
        do_reset(RESET_PC);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t6_wait_req", mif.req, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_req", mif.req, 32'h0);
        chk("t6_rst_valid", valid, 32'h0);
        chk("t6_rst_stall", stall, 32'h1);
        chk("t6_rst_pc_out", pc_out, 32'h0);
        chk("t6_rst_instr", instr, 32'h0);
        @(negedge clk);
        rst_n        = 1'b1;
        late_ack_req = 1'b1;
        #2;
        chk("t6_idle_req", mif.req, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t6_restart_req", mif.req, 32'h1);
        chk("t6_restart_addr", mif.addr, RESET_PC);
        chk("t6_late_ack_ignored", valid, 32'h0);
        repeat (4) cyc(1'b0, 1'b0, 32'h0);
        chk("t6_valid", valid, 32'h1);
        chk("t6_pc_out", pc_out, RESET_PC + 32'h4);
        chk("t6_instr", instr, mem_word(RESET_PC));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
